// File: rtl/toaplan2_cen_pkg.sv
// toaplan2_cen_pkg: shared width default and 96 MHz phase-increment constants
// for the Toaplan2 clock-enable generator.
package toaplan2_cen_pkg;
    localparam int W_DEF = 32;
    localparam logic [31:0] INC_13P5   = 32'd603979776;
    localparam logic [31:0] INC_6P75   = 32'd301989888;
    localparam logic [31:0] INC_3P375  = 32'd150994944;
    localparam logic [31:0] INC_1P6875 = 32'd75497472;
endpackage

// File: rtl/toaplan2_cen_ch.sv
// toaplan2_cen_ch: one fractional clock-enable channel (accumulator, increment, mid-period strobe).
// Optional half-rate strobe when TOAPLAN2_CEN_HALF_EN is defined.
module toaplan2_cen_ch #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] inc,
    input  logic         upd,
    input  logic         sync,
    input  logic         pause,
    output logic         cen,
    output logic         cenb,
    output logic         cenh
);
    logic [W-1:0] acc, inc_q, sum;
    logic         carry, run;
    assign {carry, sum} = {1'b0, acc} + {1'b0, inc_q};
    assign run = ~sync & ~pause;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc   <= '0;
            inc_q <= '0;
            cen   <= 1'b0;
            cenb  <= 1'b0;
        end else begin
            inc_q <= upd ? inc : inc_q;
            acc   <= sync ? '0 : (pause ? acc : sum);
            cen   <= run & carry;
            // mid-period: MSB rises without a wrap in the same add
            cenb  <= run & ~acc[W-1] & sum[W-1] & ~carry;
        end
`ifdef TOAPLAN2_CEN_HALF_EN
    logic half_t;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            half_t <= 1'b1;
            cenh   <= 1'b0;
        end else begin
            half_t <= sync ? 1'b1 : ((run & carry) ? ~half_t : half_t);
            cenh   <= run & carry & half_t;
        end
`else
    assign cenh = 1'b0;
`endif
endmodule

// File: rtl/toaplan2_cen_gen.sv
// toaplan2_cen_gen: NCH-channel fractional clock-enable generator with shared UPD/SYNC.
// Define TOAPLAN2_CEN_HALF_EN to enable the half-rate CENH strobes.
module toaplan2_cen_gen
    import toaplan2_cen_pkg::*;
#(
    parameter int NCH = 5,
    parameter int W   = W_DEF
) (
    input  logic           CLK,
    input  logic           RESETn,
    input  logic [NCH*W-1:0] INC,
    input  logic           UPD,
    input  logic           SYNC,
    input  logic [NCH-1:0] PAUSE,
    output logic [NCH-1:0] CEN,
    output logic [NCH-1:0] CENB,
    output logic [NCH-1:0] CENH
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        toaplan2_cen_ch #(.W(W)) u_ch (
            .clk  (CLK),
            .rst_n(RESETn),
            .inc  (INC[i*W +: W]),
            .upd  (UPD),
            .sync (SYNC),
            .pause(PAUSE[i]),
            .cen  (CEN[i]),
            .cenb (CENB[i]),
            .cenh (CENH[i])
        );
    end
endmodule

// File: tb/tb_toaplan2_cen_gen.sv
// tb_toaplan2_cen_gen: vector table, hand sequences and random stimulus checked
// against a wide-integer phase model of the clock-enable generator.
module tb_toaplan2_cen_gen;
    import toaplan2_cen_pkg::*;
    localparam int NCH = 5;
    localparam int W   = 32;
    localparam longint unsigned TWO_W  = 64'h1_0000_0000;
    localparam longint unsigned HALF_W = 64'h8000_0000;
    localparam logic [W-1:0] Q = 32'h4000_0000;
`ifdef TOAPLAN2_CEN_HALF_EN
    localparam bit HALF_EN = 1'b1;
`else
    localparam bit HALF_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESETn = 1'b0;
    logic [NCH*W-1:0] INC = '0;
    logic             UPD = 1'b0;
    logic             SYNC = 1'b0;
    logic [NCH-1:0]   PAUSE = '0;
    logic [NCH-1:0]   CEN, CENB, CENH;

    toaplan2_cen_gen #(.NCH(NCH), .W(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .INC(INC), .UPD(UPD), .SYNC(SYNC),
        .PAUSE(PAUSE), .CEN(CEN), .CENB(CENB), .CENH(CENH)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase as an unbounded integer, wrap counted by comparison with 2^W.
    longint unsigned ph [NCH];
    longint unsigned inc_m [NCH];
    int              ncen [NCH];
    logic [NCH-1:0]  m_cen, m_cenb, m_cenh;

    always @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            for (int i = 0; i < NCH; i++) begin
                ph[i]    <= 0;
                inc_m[i] <= 0;
                ncen[i]  <= 0;
            end
            m_cen  <= '0;
            m_cenb <= '0;
            m_cenh <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (UPD) inc_m[i] <= longint'(INC[i*W +: W]);
                if (SYNC) begin
                    ph[i] <= 0; ncen[i] <= 0;
                    m_cen[i] <= 1'b0; m_cenb[i] <= 1'b0; m_cenh[i] <= 1'b0;
                end else if (PAUSE[i]) begin
                    m_cen[i] <= 1'b0; m_cenb[i] <= 1'b0; m_cenh[i] <= 1'b0;
                end else begin
                    ph[i]     <= (ph[i] + inc_m[i]) % TWO_W;
                    m_cen[i]  <= (ph[i] + inc_m[i]) >= TWO_W;
                    m_cenb[i] <= (ph[i] < HALF_W) && (ph[i] + inc_m[i] >= HALF_W) && (ph[i] + inc_m[i] < TWO_W);
                    m_cenh[i] <= HALF_EN && (ph[i] + inc_m[i] >= TWO_W) && (ncen[i] % 2 == 0);
                    ncen[i]   <= ncen[i] + ((ph[i] + inc_m[i] >= TWO_W) ? 1 : 0);
                end
            end
        end

    always @(negedge CLK)
        if (mon_en) begin
            check("model_cen", CEN, m_cen);
            check("model_cenb", CENB, m_cenb);
            check("model_cenh", CENH, m_cenh);
        end

    task automatic tick(input logic [NCH*W-1:0] inc, input logic upd, input logic sync,
                        input logic [NCH-1:0] pause);
        @(negedge CLK);
        INC = inc; UPD = upd; SYNC = sync; PAUSE = pause;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return INC_13P5;
            3: return INC_6P75;
            4: return INC_3P375;
            5: return INC_1P6875;
            6: return W'($urandom_range(1, 32'h1000_0000));
            default: return W'($urandom());
        endcase
    endfunction

    typedef struct packed {
        logic           upd;
        logic           sync;
        logic [NCH-1:0] pause;
        logic [NCH-1:0] cen;
        logic [NCH-1:0] cenb;
    } vec_t;
    vec_t tbl [20];

    initial begin
        int c_cen, c_h, c1, first, second, t;
        logic [NCH*W-1:0] rv;
        logic [NCH-1:0]   rp;
        tbl[0]  = '{1'b1, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[1]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[2]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h1F};
        tbl[3]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[4]  = '{1'b0, 1'b0, 5'h00, 5'h1F, 5'h00};
        tbl[5]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[6]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h1F};
        tbl[7]  = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[8]  = '{1'b0, 1'b0, 5'h00, 5'h1F, 5'h00};
        tbl[9]  = '{1'b0, 1'b0, 5'h01, 5'h00, 5'h00};
        tbl[10] = '{1'b0, 1'b0, 5'h01, 5'h00, 5'h1E};
        tbl[11] = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[12] = '{1'b0, 1'b0, 5'h00, 5'h1E, 5'h01};
        tbl[13] = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[14] = '{1'b0, 1'b0, 5'h00, 5'h01, 5'h1E};
        tbl[15] = '{1'b1, 1'b1, 5'h00, 5'h00, 5'h00};
        tbl[16] = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[17] = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h1F};
        tbl[18] = '{1'b0, 1'b0, 5'h00, 5'h00, 5'h00};
        tbl[19] = '{1'b0, 1'b0, 5'h00, 5'h1F, 5'h00};

        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        mon_en = 1'b1;
        #1;
        check("reset_cen", CEN, 0);
        check("reset_cenb", CENB, 0);
        check("reset_cenh", CENH, 0);

        // INC present but never loaded: no pulses
        for (int k = 0; k < 4; k++) begin
            tick({NCH{Q}}, 1'b0, 1'b0, '0);
            check("no_upd_pulse", {CEN, CENB, CENH}, 0);
        end

        for (int k = 0; k < 20; k++) begin
            tick({NCH{Q}}, tbl[k].upd, tbl[k].sync, tbl[k].pause);
            check($sformatf("tbl%0d_cen", k), CEN, tbl[k].cen);
            check($sformatf("tbl%0d_cenb", k), CENB, tbl[k].cenb);
        end

        // 13.5 MHz from 96 MHz: 9 pulses per 64 cycles
        tick({NCH{INC_13P5}}, 1'b1, 1'b1, '0);
        c_cen = 0; c_h = 0;
        for (int k = 0; k < 256; k++) begin
            tick({NCH{INC_13P5}}, 1'b0, 1'b0, '0);
            if (CEN[0]) c_cen++;
            if (CENH[0]) c_h++;
            check("cenh_odd", CENH[0], HALF_EN && CEN[0] && (c_cen % 2 == 1));
        end
        check("cen_64k", c_cen, 36);
        check("cenh_64k", c_h, HALF_EN ? 18 : 0);

        // pause channel 0 for 10 cycles mid-period
        tick({NCH{Q}}, 1'b1, 1'b1, '0);
        tick({NCH{Q}}, 1'b0, 1'b0, '0);
        c_cen = 0; c1 = 0;
        for (int k = 0; k < 10; k++) begin
            tick({NCH{Q}}, 1'b0, 1'b0, 5'h01);
            c_cen += int'(CEN[0]) + int'(CENB[0]) + int'(CENH[0]);
            c1 += int'(CEN[1]);
        end
        check("pause_quiet", c_cen, 0);
        check("pause_ch1_cen", c1, 2);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            tick({NCH{Q}}, 1'b0, 1'b0, '0);
            if (CEN[0] && first < 0) first = k;
        end
        check("pause_resume_delay", first, 3);

        // rate change mid-period is phase-continuous
        tick({NCH{Q}}, 1'b1, 1'b1, '0);
        tick({NCH{Q >> 1}}, 1'b1, 1'b0, '0);
        first = -1; second = -1;
        for (t = 1; t <= 20; t++) begin
            tick({NCH{Q >> 1}}, 1'b0, 1'b0, '0);
            if (CEN[0]) begin
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
        end
        check("rate_first", first, 6);
        check("rate_second", second, 14);

        // zero increment never pulses
        tick('0, 1'b1, 1'b0, '0);
        c_cen = 0;
        for (int k = 0; k < 1000; k++) begin
            tick('0, 1'b0, 1'b0, '0);
            c_cen += int'(CEN[0]) + int'(CENB[0]) + int'(CENH[0]);
        end
        check("zero_inc_quiet", c_cen, 0);

        // max increment, then asynchronous reset mid-operation
        tick({NCH{32'hFFFF_FFFF}}, 1'b1, 1'b1, '0);
        repeat (3) tick({NCH{32'hFFFF_FFFF}}, 1'b0, 1'b0, '0);
        check("max_inc_cen", CEN, 5'h1F);
        #2;
        RESETn = 1'b0;
        #1;
        check("async_rst_cen", CEN, 0);
        check("async_rst_cenb", CENB, 0);
        check("async_rst_cenh", CENH, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick({NCH{32'hFFFF_FFFF}}, 1'b0, 1'b0, '0);
            check("post_rst_quiet", {CEN, CENB, CENH}, 0);
        end

        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                rv[c*W +: W] = pick();
                rp[c] = ($urandom_range(0, 7) == 0);
            end
            tick(rv, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, rp);
        end

        @(negedge CLK);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
